spread_job_scheduler: RTL and testbench
=======================================

SPREAD_JOB_SCHEDULER -- requirements
Module: spread_job_scheduler

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one inter-month spread engine.
REQ-002 Parameter SETTLE, default 8, SHALL set the cycles the engine needs from stable inputs to final TSC.
REQ-003 Parameter FLUSH, default 2, SHALL set the cycles the engine positions are forced to zero between jobs.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester job request.
REQ-007 req_acct  input  NREQ x 8  per-requester portfolio/account id.
REQ-008 req_ready  output  NREQ  one-hot grant; a handshake completes when valid and ready are both high.
REQ-009 eng_acct  output  8  account id driving the external position/maturity fetch mux.
REQ-010 eng_zero  output  1  forces engine position inputs to zero (flush).
REQ-011 eng_tsc  input  16  engine TSC output.
REQ-012 rsp_valid, rsp_ready  output, input  1 each  result handshake.
REQ-013 rsp_id  output  clog2(NREQ)  index of the requester that owns rsp_tsc.
REQ-014 rsp_acct, rsp_tsc  output  8, 16  account id and captured TSC.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, FLUSH, RUN, CAPTURE and RESP.
REQ-017 IDLE: if any req_valid is set, assert req_ready for the round-robin winner for exactly one cycle, latch its id/acct and go to FLUSH.
REQ-018 Round-robin SHALL search from (last granted index + 1) mod NREQ; after reset the pointer SHALL make requester 0 highest priority.
REQ-019 FLUSH: eng_zero=1 and eng_acct=latched acct for FLUSH cycles, then go to RUN.
REQ-020 RUN: eng_zero=0 and eng_acct held stable; a down-counter loaded with SETTLE-1 decrements each cycle; go to CAPTURE when the count is 0 (exactly SETTLE RUN cycles).
REQ-021 CAPTURE: register eng_tsc into rsp_tsc in one cycle, then go to RESP.
REQ-022 RESP: rsp_valid=1 with rsp_id, rsp_acct and rsp_tsc stable until rsp_ready; go to IDLE on the handshake cycle.
REQ-023 Grant-to-rsp_valid latency SHALL be exactly 1+FLUSH+SETTLE+1 cycles (default 12).
REQ-024 eng_acct SHALL not change from the first FLUSH cycle until CAPTURE completes.
REQ-025 A requester deasserting req_valid is ignored outside the grant cycle; requests are never dropped or duplicated.
REQ-026 No new grant SHALL issue while busy=1; req_ready SHALL be all zeros outside the grant cycle.
REQ-027 With rsp_ready held high, back-to-back jobs SHALL issue the next grant on the cycle after the RESP handshake.
REQ-028 Counters SHALL be sized clog2(max(SETTLE,FLUSH)+1) and never wrap.

Reset
REQ-029 Reset SHALL force: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_acct 0, rsp_tsc 0, eng_acct 0, eng_zero 1, busy 0, RR pointer to NREQ-1.
REQ-030 Reset mid-job SHALL abandon the job with no response; the requester must re-request.

Structure
REQ-031 State enum, default SETTLE/FLUSH and the TSC width (16) SHALL reside in the shared span package.
REQ-032 The round-robin arbiter SHALL be one sub-module, rr_arbiter (NREQ request, one-hot grant, pointer update on the grant strobe).

Verification
REQ-033 Single job: req_valid=0001, acct=0x15, eng_tsc=0x0123 stable -> req_ready=0001 for 1 cycle, rsp_valid 12 cycles after the grant, rsp_id=0, rsp_acct=0x15, rsp_tsc=0x0123.
REQ-034 All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0, and each grant follows the previous RESP handshake by 1 cycle.
REQ-035 Backpressure: rsp_ready=0 for 20 cycles in RESP -> rsp_* outputs stable, no new grant; rsp_ready=1 -> IDLE on the next cycle.
REQ-036 Flush check: during the FLUSH cycles eng_zero=1; during RUN, eng_acct is unchanged and eng_zero=0.
REQ-037 Reset asserted in cycle 5 of RUN -> all outputs at reset values immediately (asynchronously), no rsp_valid, and the next grant goes to requester 0.
REQ-038 Requester 2 drops req_valid while requester 1 is being served -> requester 2 is not granted; requester 3 is granted next if valid.

Source files
------------

// File: rtl/spread_job_scheduler_pkg.sv
// Shared types and defaults for the spread job scheduler.
// State encoding, engine timing defaults and datapath widths.
package spread_job_scheduler_pkg;

  localparam int DEF_SETTLE = 8;
  localparam int DEF_FLUSH  = 2;
  localparam int TSC_W      = 16;
  localparam int ACCT_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_CAPTURE,
    S_RESP
  } state_t;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spread_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the slot after
// the last winner; the pointer moves only on the grant strobe.
module rr_arbiter
  import spread_job_scheduler_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

  // Reset to the last slot so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= IW'(NREQ - 1);
    end else if (en && found) begin
      ptr <= idx;
    end
  end

endmodule

// File: rtl/spread_job_scheduler.sv
// Shares one inter-month spread engine between NREQ requesters:
// grant, flush, settle, capture TSC, then hand back the result.
module spread_job_scheduler
  import spread_job_scheduler_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int SETTLE = DEF_SETTLE,
  parameter  int FLUSH  = DEF_FLUSH,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW     = $clog2(max2(SETTLE, FLUSH) + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ACCT_W-1:0] req_acct,
  output logic [NREQ-1:0]        req_ready,
  output logic [ACCT_W-1:0]      eng_acct,
  output logic                   eng_zero,
  input  logic [TSC_W-1:0]       eng_tsc,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IW-1:0]          rsp_id,
  output logic [ACCT_W-1:0]      rsp_acct,
  output logic [TSC_W-1:0]       rsp_tsc,
  output logic                   busy
);

  state_t            state, nstate;
  logic [CW-1:0]     cnt, cnt_n;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     widx;
  logic              grant_en;
  logic              cap;
  logic [ACCT_W-1:0] acct_q;
  logic [IW-1:0]     id_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (grant_en),
    .gnt   (gnt),
    .idx   (widx)
  );

  always_comb begin
    nstate    = state;
    cnt_n     = cnt;
    grant_en  = 1'b0;
    cap       = 1'b0;
    busy      = 1'b1;
    eng_zero  = 1'b1;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (|req_valid) begin
          grant_en = 1'b1;
          nstate   = S_FLUSH;
          cnt_n    = CW'(FLUSH - 1);
        end
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          nstate = S_RUN;
          cnt_n  = CW'(SETTLE - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_RUN: begin
        eng_zero = 1'b0;
        if (cnt == '0) begin
          nstate = S_CAPTURE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_CAPTURE: begin
        eng_zero = 1'b0;
        cap      = 1'b1;
        nstate   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          nstate = S_IDLE;
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Grant is combinational so the handshake lands in the IDLE cycle.
  assign req_ready = (grant_en && !reset) ? gnt : '0;
  assign eng_acct  = acct_q;
  assign rsp_acct  = acct_q;
  assign rsp_id    = id_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acct_q  <= '0;
      id_q    <= '0;
      rsp_tsc <= '0;
    end else begin
      state <= nstate;
      cnt   <= cnt_n;
      if (grant_en) begin
        acct_q <= req_acct[widx*ACCT_W +: ACCT_W];
        id_q   <= widx;
      end
      if (cap) begin
        rsp_tsc <= eng_tsc;
      end
    end
  end

endmodule

// File: tb/tb_spread_job_scheduler.sv
// Self-checking bench for spread_job_scheduler with a
// transaction-level reference model of grants and responses.
module tb_spread_job_scheduler;

  localparam int N   = 4;
  localparam int LAT = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_acct;
  logic [N-1:0]  req_ready;
  logic [7:0]    eng_acct;
  logic          eng_zero;
  logic [15:0]   eng_tsc;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [7:0]    rsp_acct;
  logic [15:0]   rsp_tsc;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ptr_m  = N - 1;
  logic [15:0] tsc_hist [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) tsc_hist[cyc] = eng_tsc;

  spread_job_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_acct  (req_acct),
    .req_ready (req_ready),
    .eng_acct  (eng_acct),
    .eng_zero  (eng_zero),
    .eng_tsc   (eng_tsc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_acct  (rsp_acct),
    .rsp_tsc   (rsp_tsc),
    .busy      (busy)
  );

  // First valid requester scanning upward from the one after last.
  function automatic int winner(logic [N-1:0] v, int last);
    for (int d = 1; d <= N; d++)
      if (v[(last + d) % N]) return (last + d) % N;
    return -1;
  endfunction

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    sample();
    drive();
    reset = 1'b0;
    ptr_m = N - 1;
  endtask

  task automatic test_reset();
    sample();
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_acct, rsp_tsc,
         eng_acct, eng_zero, busy} !==
        {4'b0, 1'b0, 2'b0, 8'h0, 16'h0, 8'h0, 1'b1, 1'b0})
      $display("FAIL reset_vals got=%h %b %h %h %h %h %b %b want=0 0 0 0 0 0 1 0",
               req_ready, rsp_valid, rsp_id, rsp_acct, rsp_tsc,
               eng_acct, eng_zero, busy);
    if ({req_ready, rsp_valid, rsp_id, rsp_acct, rsp_tsc,
         eng_acct, eng_zero, busy} !==
        {4'b0, 1'b0, 2'b0, 8'h0, 16'h0, 8'h0, 1'b1, 1'b0})
      errors++;
    drive();
    reset = 1'b0;
    req_valid = '0;
    ptr_m = N - 1;
  endtask

  task automatic test_single();
    logic [13:0] obs, exp;
    logic [25:0] held;
    req_valid = 4'b0001;
    req_acct[7:0] = 8'h15;
    eng_tsc = 16'h0123;
    rsp_ready = 1'b0;
    sample();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got=%b want=0001", req_ready);
    end
    ptr_m = 0;
    drive();
    req_valid = '0;
    for (int k = 1; k <= LAT; k++) begin
      sample();
      obs = {rsp_valid, eng_zero, eng_acct, req_ready};
      exp = {k == LAT, (k <= 2) || (k == LAT), 8'h15, 4'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_seq k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    checks++;
    if ({rsp_id, rsp_acct, rsp_tsc} !== {2'd0, 8'h15, 16'h0123}) begin
      errors++;
      $display("FAIL single_rsp got=%h %h %h want=0 15 0123",
               rsp_id, rsp_acct, rsp_tsc);
    end
    held = {rsp_id, rsp_acct, rsp_tsc};
    drive();
    req_valid = 4'b0100;
    eng_tsc = 16'hbeef;
    repeat (20) begin
      sample();
      checks++;
      if ({rsp_valid, rsp_id, rsp_acct, rsp_tsc, req_ready, busy} !==
          {1'b1, held, 4'b0, 1'b1}) begin
        errors++;
        $display("FAIL backpressure got=%b %h %b %b want=1 %h 0000 1",
                 rsp_valid, {rsp_id, rsp_acct, rsp_tsc}, req_ready, busy, held);
      end
    end
    drive();
    req_valid = '0;
    rsp_ready = 1'b1;
    sample();
    drive();
    rsp_ready = 1'b0;
    sample();
    checks++;
    if ({busy, rsp_valid, req_ready} !== 6'b0) begin
      errors++;
      $display("FAIL bp_release got=%b %b %b want=0 0 0000",
               busy, rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int ng, nr, g, hs, w;
    logic [7:0] ea;
    int order [5] = '{0, 1, 2, 3, 0};
    ng = 0; nr = 0; g = -100; hs = -1; w = 0; ea = '0;
    do_reset();
    req_valid = 4'hf;
    req_acct = $urandom;
    eng_tsc = 16'($urandom);
    rsp_ready = 1'b1;
    for (int t = 0; t < 200 && nr < 5; t++) begin
      sample();
      if (req_ready !== 4'b0) begin
        checks++;
        if (ng > 4 || req_ready !== 4'(1 << order[ng])) begin
          errors++;
          $display("FAIL b2b_order n=%0d got=%b", ng, req_ready);
        end
        if (hs >= 0) begin
          checks++;
          if (cyc !== hs + 1) begin
            errors++;
            $display("FAIL b2b_gap got=%0d want=%0d", cyc - hs, 1);
          end
        end
        g = cyc;
        w = (ng > 4) ? 0 : order[ng];
        ea = req_acct[w*8 +: 8];
        ptr_m = w;
        ng++;
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if ({cyc - g, rsp_id, rsp_acct, rsp_tsc} !==
            {LAT, 2'(w), ea, tsc_hist[g + 11]}) begin
          errors++;
          $display("FAIL b2b_rsp got=%0d %h %h %h want=%0d %h %h %h",
                   cyc - g, rsp_id, rsp_acct, rsp_tsc,
                   LAT, 2'(w), ea, tsc_hist[g + 11]);
        end
        hs = cyc;
        nr++;
      end
      drive();
      req_acct = $urandom;
      eng_tsc = 16'($urandom);
    end
    checks++;
    if (nr < 5) begin
      errors++;
      $display("FAIL b2b_timeout got=%0d want=5 responses", nr);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req_valid = 4'b0010;
    req_acct = 32'ha1b2c3d4;
    rsp_ready = 1'b1;
    sample();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL mid_grant got=%b want=0010", req_ready);
    end
    drive();
    req_valid = '0;
    repeat (6) drive();
    reset = 1'b1;
    req_valid = 4'hf;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_acct, rsp_tsc,
         eng_acct, eng_zero, busy} !==
        {4'b0, 1'b0, 2'b0, 8'h0, 16'h0, 8'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_async got=%h %b %h %h %h %h %b %b want=0 0 0 0 0 0 1 0",
               req_ready, rsp_valid, rsp_id, rsp_acct, rsp_tsc,
               eng_acct, eng_zero, busy);
    end
    drive();
    reset = 1'b0;
    ptr_m = N - 1;
    sample();
    checks++;
    if (req_ready !== 4'(1 << winner(4'hf, ptr_m))) begin
      errors++;
      $display("FAIL mid_regrant got=%b want=0001", req_ready);
    end
    ptr_m = 0;
    drive();
    req_valid = '0;
    repeat (6) begin
      sample();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_rsp got=%b want=0", rsp_valid);
      end
    end
  endtask

  task automatic test_drop();
    int e;
    do_reset();
    req_valid = 4'b0010;
    req_acct = $urandom;
    rsp_ready = 1'b1;
    sample();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL drop_grant1 got=%b want=0010", req_ready);
    end
    ptr_m = 1;
    drive();
    req_valid = 4'b1100;
    repeat (4) begin
      sample();
      checks++;
      if (req_ready !== 4'b0) begin
        errors++;
        $display("FAIL drop_busy got=%b want=0000", req_ready);
      end
    end
    drive();
    req_valid = 4'b1000;
    for (int t = 0; t < 30; t++) begin
      sample();
      if (req_ready !== 4'b0) break;
    end
    e = winner(req_valid, ptr_m);
    checks++;
    if (req_ready !== 4'(1 << e)) begin
      errors++;
      $display("FAIL drop_next got=%b want=%b", req_ready, 4'(1 << e));
    end
    ptr_m = e;
    drive();
    req_valid = '0;
  endtask

  task automatic test_random();
    bit mbusy;
    int g, w, e, ph;
    logic [7:0] ea;
    logic [3:0] exp_rr;
    bit exp_rv, exp_z;
    mbusy = 0; g = 0; w = 0; ea = '0;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      req_valid = 4'($urandom) & 4'($urandom);
      req_acct = $urandom;
      eng_tsc = 16'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      sample();
      ph = cyc - g;
      exp_rv = mbusy && (ph >= LAT);
      exp_z = !(mbusy && ph >= 3 && ph <= 11);
      e = mbusy ? -1 : winner(req_valid, ptr_m);
      exp_rr = (e >= 0) ? 4'(1 << e) : 4'b0;
      checks++;
      if ({req_ready, rsp_valid, busy, eng_zero} !==
          {exp_rr, exp_rv, mbusy, exp_z}) begin
        errors++;
        $display("FAIL rand_ctl cyc=%0d got=%b %b %b %b want=%b %b %b %b",
                 cyc, req_ready, rsp_valid, busy, eng_zero,
                 exp_rr, exp_rv, mbusy, exp_z);
      end
      if (mbusy && ph <= 11) begin
        checks++;
        if (eng_acct !== ea) begin
          errors++;
          $display("FAIL rand_acct cyc=%0d got=%h want=%h", cyc, eng_acct, ea);
        end
      end
      if (exp_rv) begin
        checks++;
        if ({rsp_id, rsp_acct, rsp_tsc} !== {2'(w), ea, tsc_hist[g + 11]}) begin
          errors++;
          $display("FAIL rand_rsp cyc=%0d got=%h %h %h want=%h %h %h",
                   cyc, rsp_id, rsp_acct, rsp_tsc, 2'(w), ea, tsc_hist[g + 11]);
        end
      end
      if (e >= 0) begin
        mbusy = 1;
        g = cyc;
        w = e;
        ea = req_acct[e*8 +: 8];
        ptr_m = e;
      end else if (exp_rv && rsp_ready) begin
        mbusy = 0;
      end
      drive();
    end
    req_valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 4'hf;
    req_acct = '0;
    eng_tsc = 16'h0123;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_run();
    test_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
